// File: rtl/sayuru_mem_responder.sv
// Word-addressed req/gnt/rvalid memory responder with fixed grant and response latencies.
// Define SAYURU_MEM_STATS_EN to build the live read/write completion counters.
module sayuru_mem_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int GNT_LATENCY    = 2,
    parameter int RVALID_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output int                      read_count,
    output int                      write_count
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int MEM_DEPTH = 2 ** IDX_WIDTH;
    localparam logic [3:0] GNT_LOAD  = 4'((GNT_LATENCY == 0) ? 0 : GNT_LATENCY - 1);
    localparam logic [3:0] RESP_LOAD = 4'(RVALID_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, GNT_WAIT, RESP_WAIT, RESP} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic                   gnt_next, rvalid_next;
    logic [DATA_WIDTH-1:0]  rdata_next;
    logic                   grant_fire, mem_fire;

    logic [IDX_WIDTH-1:0]   idx_reg;
    logic                   we_reg;
    logic [NUM_BYTES-1:0]   be_reg;
    logic [DATA_WIDTH-1:0]  wdata_reg;

    logic [IDX_WIDTH-1:0]   txn_idx;
    logic                   txn_we;
    logic [NUM_BYTES-1:0]   txn_be;
    logic [DATA_WIDTH-1:0]  txn_wdata;
    logic [DATA_WIDTH-1:0]  resp_word;

    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            gnt_o     <= 1'b0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            idx_reg   <= '0;
            we_reg    <= 1'b0;
            be_reg    <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            gnt_o     <= gnt_next;
            rvalid_o  <= rvalid_next;
            rdata_o   <= rdata_next;
            if (state_reg == IDLE && req_i) begin
                idx_reg   <= addr_i[ADDR_WIDTH-1:2];
                we_reg    <= we_i;
                be_reg    <= be_i;
                wdata_reg <= wdata_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (req_i) state_next = (GNT_LATENCY == 0) ? RESP_WAIT : GNT_WAIT;
            GNT_WAIT:  if (cnt_reg == 4'd0) state_next = RESP_WAIT;
            RESP_WAIT: if (cnt_reg == 4'd0) state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next    = cnt_reg;
        gnt_next    = 1'b0;
        rvalid_next = 1'b0;
        rdata_next  = '0;
        grant_fire  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_i) begin
                    if (GNT_LATENCY == 0) begin
                        gnt_next   = 1'b1;
                        grant_fire = 1'b1;
                        cnt_next   = RESP_LOAD;
                    end else begin
                        cnt_next = GNT_LOAD;
                    end
                end
            end
            GNT_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    gnt_next   = 1'b1;
                    grant_fire = 1'b1;
                    cnt_next   = RESP_LOAD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    rvalid_next = 1'b1;
                    rdata_next  = we_reg ? '0 : resp_word;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: ;
        endcase
    end

    // With zero grant latency the grant edge is the sample edge, so use the live request fields.
    assign txn_idx   = (state_reg == IDLE) ? addr_i[ADDR_WIDTH-1:2] : idx_reg;
    assign txn_we    = (state_reg == IDLE) ? we_i    : we_reg;
    assign txn_be    = (state_reg == IDLE) ? be_i    : be_reg;
    assign txn_wdata = (state_reg == IDLE) ? wdata_i : wdata_reg;
    assign mem_fire  = grant_fire & ~rst_i;

    // One byte-wide RAM per lane keeps byte-enable writes simple and block-RAM friendly.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        logic [7:0] lane_mem [MEM_DEPTH];
        logic [7:0] rd_byte_reg;

        always_ff @(posedge clk_i) begin
            if (mem_fire) begin
                if (txn_we) begin
                    if (txn_be[gi]) lane_mem[txn_idx] <= txn_wdata[gi*8 +: 8];
                end else begin
                    rd_byte_reg <= lane_mem[txn_idx];
                end
            end
        end

        assign resp_word[gi*8 +: 8] = rd_byte_reg;
    end

`ifdef SAYURU_MEM_STATS_EN
    int read_count_reg, write_count_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            read_count_reg  <= 0;
            write_count_reg <= 0;
        end else if (rvalid_next) begin
            if (we_reg) write_count_reg <= write_count_reg + 1;
            else        read_count_reg  <= read_count_reg + 1;
        end
    end

    assign read_count  = read_count_reg;
    assign write_count = write_count_reg;
`else
    assign read_count  = 0;
    assign write_count = 0;
`endif

endmodule

// File: tb/tb_sayuru_mem_responder.sv
// Directed bench for sayuru_mem_responder: default latencies plus a zero-grant-latency instance.
module tb_sayuru_mem_responder;

`ifdef SAYURU_MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int GL = 2;
    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [15:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    int          rd_cnt, wr_cnt;

    logic        f_req = 1'b0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    int          f_rd_cnt, f_wr_cnt;

    int checks = 0;
    int failures = 0;
    int exp_reads = 0;
    int exp_writes = 0;

    always #5 clk = ~clk;

    sayuru_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .GNT_LATENCY(GL), .RVALID_LATENCY(RL)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .rvalid_o(rvalid),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rdata),
        .read_count(rd_cnt), .write_count(wr_cnt)
    );

    sayuru_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .GNT_LATENCY(0), .RVALID_LATENCY(1)) u_fast (
        .clk_i(clk), .rst_i(rst), .req_i(f_req), .gnt_o(f_gnt), .rvalid_o(f_rvalid),
        .addr_i(16'h0010), .we_i(1'b0), .be_i(4'hF), .wdata_i(32'h0), .rdata_o(f_rdata),
        .read_count(f_rd_cnt), .write_count(f_wr_cnt)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic t_we, input logic [15:0] t_addr,
                           input logic [3:0] t_be, input logic [31:0] t_wdata,
                           input bit hold, input logic [31:0] exp_rdata);
        int gnt_k = -1;
        int rv_k = -1;
        int pulses = 0;
        bit overlap = 0;
        logic [31:0] rv_data = '0;
        req = 1'b1; we = t_we; addr = t_addr; be = t_be; wdata = t_wdata;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (gnt && rvalid) overlap = 1;
            if (gnt) begin
                pulses++;
                if (gnt_k < 0) gnt_k = k;
            end
            if (gnt_k >= 0 && k == gnt_k && !hold) req = 1'b0;
            if (gnt_k >= 0 && k == gnt_k + 1) req = 1'b0;
            if (rvalid) begin
                rv_k = k;
                rv_data = rdata;
                break;
            end
        end
        req = 1'b0;
        if (t_we) exp_writes++; else exp_reads++;
        check({tag, " gnt_latency"}, gnt_k - 1, GL);
        check({tag, " rvalid_latency"}, rv_k - gnt_k, RL);
        check({tag, " gnt_pulses"}, pulses, 1);
        check({tag, " overlap"}, {31'b0, overlap}, 0);
        check({tag, " rdata"}, rv_data, exp_rdata);
        @(posedge clk); #1;
        check({tag, " rvalid_clear"}, {31'b0, rvalid}, 0);
        check({tag, " rdata_clear"}, rdata, 0);
        $display("txn %s we=%0d addr=0x%04h be=0x%h wdata=0x%08h gnt_k=%0d rv_k=%0d rdata=0x%08h",
                 tag, t_we, t_addr, t_be, t_wdata, gnt_k, rv_k, rv_data);
    endtask

    task automatic check_counts(input string tag);
        check({tag, " read_count"}, rd_cnt, STATS ? exp_reads : 0);
        check({tag, " write_count"}, wr_cnt, STATS ? exp_writes : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gnt_seen;
        int rv_seen;
        int last_gnt;
        bit f_overlap;
        bit gap_bad;

        vecs[0]  = '{1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 16'h0010, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{1'b1, 16'h0020, 4'hF, 32'h11223344, 32'h0};
        vecs[3]  = '{1'b1, 16'h0020, 4'h5, 32'hAABBCCDD, 32'h0};
        vecs[4]  = '{1'b0, 16'h0020, 4'hF, 32'h0,        32'h11BB33DD};
        vecs[5]  = '{1'b1, 16'h0041, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[6]  = '{1'b0, 16'h0040, 4'hF, 32'h0,        32'hCAFEF00D};
        vecs[7]  = '{1'b0, 16'h0044, 4'hF, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 16'h0050, 4'h8, 32'h12345678, 32'h0};
        vecs[9]  = '{1'b0, 16'h0050, 4'hF, 32'h0,        32'h12000000};
        vecs[10] = '{1'b0, 16'h0013, 4'h0, 32'h0,        32'hDEADBEEF};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset gnt", {31'b0, gnt}, 0);
        check("reset rvalid", {31'b0, rvalid}, 0);
        check("reset rdata", rdata, 0);
        check("reset read_count", rd_cnt, 0);
        check("reset write_count", wr_cnt, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be,
                    vecs[i].wdata, 1'b0, vecs[i].exp_rdata);
        end
        check_counts("table");

        // Requester keeps req_i high for one cycle after the grant.
        run_txn("hold_write", 1'b1, 16'h0060, 4'hF, 32'h0BADF00D, 1'b1, 32'h0);
        gnt_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (gnt || rvalid) gnt_seen++;
        end
        check("hold extra_pulses", gnt_seen, 0);
        check_counts("hold");
        run_txn("hold_read", 1'b0, 16'h0060, 4'hF, 32'h0, 1'b0, 32'h0BADF00D);

        // Reset lands while a write to 0x0030 waits for its grant.
        req = 1'b1; we = 1'b1; addr = 16'h0030; be = 4'hF; wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        #1 rst = 1'b1;
        #1;
        check("midrst gnt", {31'b0, gnt}, 0);
        check("midrst rvalid", {31'b0, rvalid}, 0);
        check("midrst rdata", rdata, 0);
        check("midrst read_count", rd_cnt, 0);
        check("midrst write_count", wr_cnt, 0);
        req = 1'b0;
        gnt_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (gnt || rvalid) gnt_seen++;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (gnt || rvalid) gnt_seen++;
        end
        check("midrst pulses", gnt_seen, 0);
        exp_reads = 0;
        exp_writes = 0;
        run_txn("post_rst_read", 1'b0, 16'h0030, 4'hF, 32'h0, 1'b0, 32'h0);
        check_counts("post_rst");

        // Zero grant latency instance with req_i held high across four reads.
        gnt_seen = 0; rv_seen = 0; last_gnt = -1; f_overlap = 0; gap_bad = 0;
        f_req = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (f_gnt && f_rvalid) f_overlap = 1;
            if (f_gnt) begin
                if (gnt_seen == 0 && k != 1) gap_bad = 1;
                if (last_gnt >= 0 && k - last_gnt != 3) gap_bad = 1;
                last_gnt = k;
                gnt_seen++;
                $display("fast gnt at cycle %0d", k);
            end
            if (f_rvalid) begin
                rv_seen++;
                $display("fast rvalid at cycle %0d rdata=0x%08h", k, f_rdata);
                if (rv_seen == 4) begin
                    f_req = 1'b0;
                    break;
                end
            end
        end
        f_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (f_gnt) gnt_seen++;
            if (f_rvalid) rv_seen++;
        end
        check("fast gnt_count", gnt_seen, 4);
        check("fast rvalid_count", rv_seen, 4);
        check("fast gnt_spacing", {31'b0, gap_bad}, 0);
        check("fast overlap", {31'b0, f_overlap}, 0);
        check("fast read_count", f_rd_cnt, STATS ? 4 : 0);
        check("fast write_count", f_wr_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
